// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared types, command encodings and default widths for the counter sweep sequencer.
package counter_ctrl_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DWELL_W = 4;
    localparam int DEF_REP_W   = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEEK     = 3'd1,
        UP       = 3'd2,
        DWELL_HI = 3'd3,
        DOWN     = 3'd4,
        DWELL_LO = 3'd5,
        DONE     = 3'd6
    } sweep_state_e;

    // Counter commands as {s0, s1}.
    localparam logic [1:0] CMD_HOLD = 2'b10;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b00;

    function automatic logic is_dwell(input sweep_state_e st);
        return (st == DWELL_HI) || (st == DWELL_LO);
    endfunction

endpackage

// File: rtl/counter_sweep_ctrl_dwell_timer.sv
// Loadable down-counter timing the holds at each sweep bound; expired_o is high at zero.
module sweep_dwell_timer
    import counter_ctrl_pkg::*;
#(
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               expired_o
);

    logic [DWELL_W:0] count_q;
    logic [DWELL_W:0] count_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = {1'b0, load_val_i};
        end else if (dec_i && (count_q != {(DWELL_W+1){1'b0}})) begin
            count_d = count_q - (DWELL_W+1)'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {(DWELL_W+1){1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == {(DWELL_W+1){1'b0}});

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Drives the up/down counter's s0/s1 pins through bounded triangular sweeps.
// Define SWEEP_CHECK_EN to add the cnt_in consistency monitor and its mismatch output.
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int REP_W   = DEF_REP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [REP_W-1:0]   reps,
    input  logic [WIDTH-1:0]   cnt_in,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [REP_W-1:0]   rep_cnt
`ifdef SWEEP_CHECK_EN
    ,
    output logic               mismatch
`endif
);

    sweep_state_e       state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [WIDTH-1:0]   pos_q, pos_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               tmr_load_s;
    logic               tmr_expired_s;
    logic               start_ok_s;
    logic               fault_s;
    logic [REP_W-1:0]   rep_inc_s;
    logic [WIDTH-1:0]   pos_up_s;
    logic [WIDTH-1:0]   pos_dn_s;

    assign start_ok_s = start && (lo < hi) && (reps != {REP_W{1'b0}});
    assign rep_inc_s  = rep_cnt_q + REP_W'(1);
    assign pos_up_s   = pos_q + WIDTH'(1);
    assign pos_dn_s   = pos_q - WIDTH'(1);

    sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load_s),
        .dec_i      (is_dwell(state_q)),
        .load_val_i (dwell_q),
        .expired_o  (tmr_expired_s)
    );

`ifdef SWEEP_CHECK_EN
    logic [WIDTH-1:0] pos_dly_q;
    logic             chk_arm_q;
    logic             mismatch_q, mismatch_d;

    // cnt_in lags pos by one cycle; skip the first busy cycle, where pos_dly is stale.
    assign fault_s = chk_arm_q && (state_q != IDLE) && (cnt_in != pos_dly_q);

    // Sticky flag, cleared only by the next accepted start.
    always_comb begin
        mismatch_d = mismatch_q;
        if (fault_s) begin
            mismatch_d = 1'b1;
        end else if ((state_q == IDLE) && !abort && start_ok_s) begin
            mismatch_d = 1'b0;
        end else begin
            mismatch_d = mismatch_q;
        end
    end

    // Delayed position and monitor registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_dly_q  <= {WIDTH{1'b0}};
            chk_arm_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            pos_dly_q  <= pos_q;
            chk_arm_q  <= busy_q;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign fault_s = 1'b0;
`endif

    // Sweep sequencing. The edges leaving a dwell issue the first step directly, so
    // a bound is held for exactly dwell+1 cycles.
    always_comb begin
        state_d    = state_q;
        cmd_d      = CMD_HOLD;
        pos_d      = pos_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        dwell_d    = dwell_q;
        reps_d     = reps_q;
        rep_cnt_d  = rep_cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tmr_load_s = 1'b0;
        if (abort || fault_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && start_ok_s) begin
                        lo_d      = lo;
                        hi_d      = hi;
                        dwell_d   = dwell;
                        reps_d    = reps;
                        pos_d     = cnt_in;
                        rep_cnt_d = {REP_W{1'b0}};
                        state_d   = SEEK;
                    end else if (start) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SEEK: begin
                    if (pos_q < lo_q) begin
                        cmd_d = CMD_UP;
                        pos_d = pos_up_s;
                    end else if (pos_q > lo_q) begin
                        cmd_d = CMD_DOWN;
                        pos_d = pos_dn_s;
                    end else begin
                        state_d = UP;
                    end
                end
                UP: begin
                    if (pos_q < hi_q) begin
                        cmd_d = CMD_UP;
                        pos_d = pos_up_s;
                    end else begin
                        tmr_load_s = 1'b1;
                        state_d    = DWELL_HI;
                    end
                end
                DWELL_HI: begin
                    if (tmr_expired_s) begin
                        cmd_d   = CMD_DOWN;
                        pos_d   = pos_dn_s;
                        state_d = DOWN;
                    end else begin
                        state_d = DWELL_HI;
                    end
                end
                DOWN: begin
                    if (pos_q > lo_q) begin
                        cmd_d = CMD_DOWN;
                        pos_d = pos_dn_s;
                    end else begin
                        rep_cnt_d = rep_inc_s;
                        if (rep_inc_s == reps_q) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            tmr_load_s = 1'b1;
                            state_d    = DWELL_LO;
                        end
                    end
                end
                DWELL_LO: begin
                    if (tmr_expired_s) begin
                        cmd_d   = CMD_UP;
                        pos_d   = pos_up_s;
                        state_d = UP;
                    end else begin
                        state_d = DWELL_LO;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_HOLD;
            pos_q     <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            dwell_q   <= {DWELL_W{1'b0}};
            reps_q    <= {REP_W{1'b0}};
            rep_cnt_q <= {REP_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            pos_q     <= pos_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            dwell_q   <= dwell_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign s0      = cmd_q[1];
    assign s1      = cmd_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rep_cnt = rep_cnt_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl with a behavioural up/down counter in the loop.
// Define SWEEP_CHECK_EN to also exercise the mismatch monitor.
module tb_counter_sweep_ctrl;

    // Per-cycle expected output vector {s0, s1, busy, done, err}.
    localparam logic [4:0] HOLD_B = 5'b10100;
    localparam logic [4:0] UP_B   = 5'b01100;
    localparam logic [4:0] DN_B   = 5'b00100;
    localparam logic [4:0] DONE_B = 5'b10110;
    localparam logic [4:0] IDLE_B = 5'b10000;

    logic       clk_s = 1'b0;
    logic       rst_s, start_s, abort_s;
    logic [7:0] lo_s, hi_s, cnt_in_s, force_val_s, cnt_set_val_s;
    logic [7:0] cnt_r = 8'd0;
    logic [3:0] dwell_s, reps_s, rep_cnt_s;
    logic       s0_s, s1_s, busy_s, done_s, err_s, cnt_set_s, force_en_s;
`ifdef SWEEP_CHECK_EN
    logic       mismatch_s;
`endif

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    logic [4:0] sb_q[$];

    always #5 clk_s = ~clk_s;

    counter_sweep_ctrl dut (
        .clk     (clk_s),
        .rst     (rst_s),
        .start   (start_s),
        .abort   (abort_s),
        .lo      (lo_s),
        .hi      (hi_s),
        .dwell   (dwell_s),
        .reps    (reps_s),
        .cnt_in  (cnt_in_s),
        .s0      (s0_s),
        .s1      (s1_s),
        .busy    (busy_s),
        .done    (done_s),
        .err     (err_s),
        .rep_cnt (rep_cnt_s)
`ifdef SWEEP_CHECK_EN
        ,
        .mismatch(mismatch_s)
`endif
    );

    // The counter being steered: applies the command present on each rising edge.
    always @(posedge clk_s) begin
        if (cnt_set_s) cnt_r <= cnt_set_val_s;
        else if (!s0_s) cnt_r <= s1_s ? cnt_r + 8'd1 : cnt_r - 8'd1;
    end
    assign cnt_in_s = force_en_s ? force_val_s : cnt_r;

    // Expected visible command trace of one run, from the cycle after the start edge.
    function automatic void push_sweep(int c, int l, int h, int d, int r);
        int m;
        m = (c > l) ? c - l : l - c;
        sb_q.push_back(HOLD_B);
        for (int i = 0; i < m; i++) sb_q.push_back((c > l) ? DN_B : UP_B);
        sb_q.push_back(HOLD_B);
        for (int k = 0; k < r; k++) begin
            if (k > 0) for (int i = 0; i <= d; i++) sb_q.push_back(HOLD_B);
            for (int i = 0; i < h - l; i++) sb_q.push_back(UP_B);
            for (int i = 0; i <= d; i++) sb_q.push_back(HOLD_B);
            for (int i = 0; i < h - l; i++) sb_q.push_back(DN_B);
        end
        sb_q.push_back(DONE_B);
    endfunction

    task automatic test_reset;
        rst_s = 1'b1; start_s = 1'b0; abort_s = 1'b0;
        lo_s = 8'd0; hi_s = 8'd0; dwell_s = 4'd0; reps_s = 4'd0;
        cnt_set_s = 1'b0; cnt_set_val_s = 8'd0; force_en_s = 1'b0; force_val_s = 8'd0;
        #1;
        total_cnt++;
        if ({s0_s, s1_s, busy_s, done_s, err_s} !== IDLE_B || rep_cnt_s !== 4'd0) begin
            fail_cnt++;
            $display("FAIL reset_async: got %b rep %0d want %b rep 0", {s0_s, s1_s, busy_s, done_s, err_s}, rep_cnt_s, IDLE_B);
        end else pass_cnt++;
        @(negedge clk_s); @(negedge clk_s);
        total_cnt++;
        if ({s0_s, s1_s, busy_s, done_s, err_s} !== IDLE_B || rep_cnt_s !== 4'd0) begin
            fail_cnt++;
            $display("FAIL reset_clocked: got %b rep %0d want %b rep 0", {s0_s, s1_s, busy_s, done_s, err_s}, rep_cnt_s, IDLE_B);
        end else pass_cnt++;
`ifdef SWEEP_CHECK_EN
        total_cnt++;
        if (mismatch_s !== 1'b0) begin
            fail_cnt++; $display("FAIL reset_mismatch: got %b want 0", mismatch_s);
        end else pass_cnt++;
`endif
        rst_s = 1'b0;
    endtask

    task automatic test_basic;
        logic [4:0] exp_v;
        @(negedge clk_s); cnt_set_s = 1'b1; cnt_set_val_s = 8'd2;
        @(negedge clk_s); cnt_set_s = 1'b0;
        lo_s = 8'd2; hi_s = 8'd5; dwell_s = 4'd0; reps_s = 4'd1; start_s = 1'b1;
        push_sweep(2, 2, 5, 0, 1);
        @(negedge clk_s); start_s = 1'b0;
        lo_s = 8'hFF; hi_s = 8'h00; dwell_s = 4'hF; reps_s = 4'h0;
        while (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            total_cnt++;
            if ({s0_s, s1_s, busy_s, done_s, err_s} !== exp_v) begin
                fail_cnt++;
                $display("FAIL basic_seq: left %0d got %b want %b", sb_q.size(), {s0_s, s1_s, busy_s, done_s, err_s}, exp_v);
            end else pass_cnt++;
            @(negedge clk_s);
        end
        total_cnt++;
        if ({s0_s, s1_s, busy_s, done_s, err_s} !== IDLE_B || rep_cnt_s !== 4'd1 || cnt_r !== 8'd2) begin
            fail_cnt++;
            $display("FAIL basic_end: got %b rep %0d cnt %0d want %b rep 1 cnt 2", {s0_s, s1_s, busy_s, done_s, err_s}, rep_cnt_s, cnt_r, IDLE_B);
        end else pass_cnt++;
    endtask

    task automatic test_seek_down;
        logic [4:0] exp_v;
        int n;
        @(negedge clk_s); cnt_set_s = 1'b1; cnt_set_val_s = 8'd9;
        @(negedge clk_s); cnt_set_s = 1'b0;
        lo_s = 8'd3; hi_s = 8'd6; dwell_s = 4'd2; reps_s = 4'd2; start_s = 1'b1;
        push_sweep(9, 3, 6, 2, 2);
        @(negedge clk_s); start_s = 1'b0;
        n = 0;
        while (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            total_cnt++;
            if ({s0_s, s1_s, busy_s, done_s, err_s} !== exp_v) begin
                fail_cnt++;
                $display("FAIL seek_down_seq: step %0d got %b want %b", n, {s0_s, s1_s, busy_s, done_s, err_s}, exp_v);
            end else pass_cnt++;
            // A start while busy must be ignored without an error pulse.
            start_s = (n == 5);
            if (n == 5) begin lo_s = 8'd0; hi_s = 8'd1; reps_s = 4'd1; end
            n++;
            @(negedge clk_s);
        end
        start_s = 1'b0;
        total_cnt++;
        if ({s0_s, s1_s, busy_s, done_s, err_s} !== IDLE_B || rep_cnt_s !== 4'd2 || cnt_r !== 8'd3) begin
            fail_cnt++;
            $display("FAIL seek_down_end: got %b rep %0d cnt %0d want %b rep 2 cnt 3", {s0_s, s1_s, busy_s, done_s, err_s}, rep_cnt_s, cnt_r, IDLE_B);
        end else pass_cnt++;
    endtask

    task automatic test_config_err;
        logic [7:0] lo_t[3] = '{8'd7, 8'd3, 8'd9};
        logic [7:0] hi_t[3] = '{8'd7, 8'd9, 8'd3};
        logic [3:0] rp_t[3] = '{4'd1, 4'd0, 4'd2};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_s); lo_s = lo_t[i]; hi_s = hi_t[i]; reps_s = rp_t[i]; start_s = 1'b1;
            @(negedge clk_s); start_s = 1'b0;
            total_cnt++;
            if ({s0_s, busy_s, err_s} !== 3'b101) begin
                fail_cnt++; $display("FAIL cfg_err_pulse[%0d]: got s0/busy/err %b want 101", i, {s0_s, busy_s, err_s});
            end else pass_cnt++;
            @(negedge clk_s);
            total_cnt++;
            if ({s0_s, busy_s, err_s} !== 3'b100) begin
                fail_cnt++; $display("FAIL cfg_err_clear[%0d]: got s0/busy/err %b want 100", i, {s0_s, busy_s, err_s});
            end else pass_cnt++;
        end
    endtask

    task automatic test_abort;
        logic found;
        logic [7:0] frozen;
        @(negedge clk_s); cnt_set_s = 1'b1; cnt_set_val_s = 8'd0;
        @(negedge clk_s); cnt_set_s = 1'b0;
        lo_s = 8'd0; hi_s = 8'd10; dwell_s = 4'd0; reps_s = 4'd3; start_s = 1'b1;
        @(negedge clk_s); start_s = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (rep_cnt_s == 4'd1 && cnt_r == 8'd4 && s0_s == 1'b0 && s1_s == 1'b1) found = 1'b1;
            else @(negedge clk_s);
        end
        total_cnt++;
        if (!found) begin
            fail_cnt++; $display("FAIL abort_wait: got timeout want second climb at 4");
        end else pass_cnt++;
        abort_s = 1'b1;
        @(negedge clk_s); abort_s = 1'b0;
        frozen = cnt_r;
        total_cnt++;
        if ({s0_s, s1_s, busy_s, done_s, err_s} !== IDLE_B || rep_cnt_s !== 4'd1 || (frozen !== 8'd4 && frozen !== 8'd5)) begin
            fail_cnt++;
            $display("FAIL abort_idle: got %b rep %0d cnt %0d want %b rep 1 cnt 4or5", {s0_s, s1_s, busy_s, done_s, err_s}, rep_cnt_s, frozen, IDLE_B);
        end else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_s);
            total_cnt++;
            if (cnt_r !== frozen || done_s !== 1'b0 || busy_s !== 1'b0) begin
                fail_cnt++; $display("FAIL abort_frozen: got cnt %0d done %b busy %b want cnt %0d done 0 busy 0", cnt_r, done_s, busy_s, frozen);
            end else pass_cnt++;
        end
        // Start and abort together: start is dropped.
        lo_s = 8'd0; hi_s = 8'd5; reps_s = 4'd1; start_s = 1'b1; abort_s = 1'b1;
        @(negedge clk_s); start_s = 1'b0; abort_s = 1'b0;
        @(negedge clk_s);
        total_cnt++;
        if (busy_s !== 1'b0 || err_s !== 1'b0 || s0_s !== 1'b1) begin
            fail_cnt++; $display("FAIL start_abort: got busy %b err %b s0 %b want 0 0 1", busy_s, err_s, s0_s);
        end else pass_cnt++;
    endtask

    task automatic test_async_reset;
        logic found;
        @(negedge clk_s); cnt_set_s = 1'b1; cnt_set_val_s = 8'd0;
        @(negedge clk_s); cnt_set_s = 1'b0;
        lo_s = 8'd0; hi_s = 8'd3; dwell_s = 4'd7; reps_s = 4'd2; start_s = 1'b1;
        @(negedge clk_s); start_s = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (rep_cnt_s == 4'd1 && cnt_r == 8'd3 && s0_s == 1'b1 && busy_s == 1'b1) found = 1'b1;
            else @(negedge clk_s);
        end
        total_cnt++;
        if (!found) begin
            fail_cnt++; $display("FAIL rst_wait: got timeout want second high dwell");
        end else pass_cnt++;
        #2 rst_s = 1'b1;
        #1;
        total_cnt++;
        if ({s0_s, s1_s, busy_s, done_s, err_s} !== IDLE_B || rep_cnt_s !== 4'd0) begin
            fail_cnt++;
            $display("FAIL rst_midrun: got %b rep %0d want %b rep 0", {s0_s, s1_s, busy_s, done_s, err_s}, rep_cnt_s, IDLE_B);
        end else pass_cnt++;
        @(negedge clk_s); rst_s = 1'b0;
    endtask

    task automatic test_extremes;
        logic [4:0] exp_v;
        @(negedge clk_s); cnt_set_s = 1'b1; cnt_set_val_s = 8'd128;
        @(negedge clk_s); cnt_set_s = 1'b0;
        lo_s = 8'd0; hi_s = 8'd255; dwell_s = 4'd0; reps_s = 4'd1; start_s = 1'b1;
        push_sweep(128, 0, 255, 0, 1);
        @(negedge clk_s); start_s = 1'b0;
        while (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            total_cnt++;
            if ({s0_s, s1_s, busy_s, done_s, err_s} !== exp_v) begin
                fail_cnt++;
                $display("FAIL extremes_seq: left %0d cnt %0d got %b want %b", sb_q.size(), cnt_r, {s0_s, s1_s, busy_s, done_s, err_s}, exp_v);
            end else pass_cnt++;
            @(negedge clk_s);
        end
        total_cnt++;
        if (busy_s !== 1'b0 || rep_cnt_s !== 4'd1 || cnt_r !== 8'd0) begin
            fail_cnt++; $display("FAIL extremes_end: got busy %b rep %0d cnt %0d want 0 1 0", busy_s, rep_cnt_s, cnt_r);
        end else pass_cnt++;
`ifdef SWEEP_CHECK_EN
        total_cnt++;
        if (mismatch_s !== 1'b0) begin
            fail_cnt++; $display("FAIL extremes_mismatch: got %b want 0", mismatch_s);
        end else pass_cnt++;
`endif
    endtask

`ifdef SWEEP_CHECK_EN
    task automatic test_glitch;
        @(negedge clk_s); cnt_set_s = 1'b1; cnt_set_val_s = 8'd0;
        @(negedge clk_s); cnt_set_s = 1'b0;
        lo_s = 8'd0; hi_s = 8'd20; dwell_s = 4'd0; reps_s = 4'd1; start_s = 1'b1;
        @(negedge clk_s); start_s = 1'b0;
        repeat (8) @(negedge clk_s);
        force_val_s = cnt_r ^ 8'h80; force_en_s = 1'b1;
        @(negedge clk_s); force_en_s = 1'b0;
        total_cnt++;
        if (mismatch_s !== 1'b1 || busy_s !== 1'b0 || s0_s !== 1'b1) begin
            fail_cnt++; $display("FAIL glitch_trip: got mismatch %b busy %b s0 %b want 1 0 1", mismatch_s, busy_s, s0_s);
        end else pass_cnt++;
        @(negedge clk_s);
        lo_s = 8'd0; hi_s = 8'd40; reps_s = 4'd1; start_s = 1'b1;
        @(negedge clk_s); start_s = 1'b0;
        total_cnt++;
        if (mismatch_s !== 1'b0 || busy_s !== 1'b1) begin
            fail_cnt++; $display("FAIL glitch_clear: got mismatch %b busy %b want 0 1", mismatch_s, busy_s);
        end else pass_cnt++;
        abort_s = 1'b1;
        @(negedge clk_s); abort_s = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_seek_down();
        test_config_err();
        test_abort();
        test_async_reset();
        test_extremes();
`ifdef SWEEP_CHECK_EN
        test_glitch();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want run complete");
        $fatal(1, "watchdog expired");
    end

endmodule
